// File: rtl/alu_exec_ctrl.sv
// Command sequencer in front of a combinational 16-bit ADD/AND/NOT ALU:
// fetches operands from an 8-entry register file, writes the result back, updates NZP.
module alu_exec_ctrl #(
    parameter int DATA_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [2:0]           cmd_dr,
    input  logic [2:0]           cmd_sr1,
    input  logic [2:0]           cmd_sr2,
    input  logic                 cmd_imm_en,
    input  logic [4:0]           cmd_imm5,
    input  logic                 ld_en,
    input  logic [2:0]           ld_addr,
    input  logic [DATA_SIZE-1:0] ld_data,
    output logic [DATA_SIZE-1:0] alu_op_a,
    output logic [DATA_SIZE-1:0] alu_op_b,
    output logic [1:0]           alu_aluk,
    input  logic [DATA_SIZE-1:0] alu_y,
    input  logic                 alu_cyo,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_SIZE-1:0] rsp_data,
    output logic                 rsp_cy,
    output logic [2:0]           nzp
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                state_reg, state_next;
    logic                  accept, wb_en, rf_ld;
    logic [DATA_SIZE-1:0]  rf_reg [8];
    logic [DATA_SIZE-1:0]  op_a_reg, op_b_reg, rsp_data_reg;
    logic [1:0]            aluk_reg;
    logic [2:0]            dr_reg, nzp_reg, nzp_next;
    logic                  rsp_cy_reg;
    logic [DATA_SIZE-1:0]  imm_sext;

    assign imm_sext = {{(DATA_SIZE-5){cmd_imm5[4]}}, cmd_imm5};

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        wb_en      = 1'b0;
        rf_ld      = 1'b0;
        case (state_reg)
            IDLE: begin
                rf_ld = ld_en;
                if (cmd_valid) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                wb_en      = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        nzp_next = {alu_y[DATA_SIZE-1], alu_y == '0, !alu_y[DATA_SIZE-1] && (alu_y != '0)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operands are read from the pre-edge file contents, so a same-edge load is not seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_reg <= '0;
            op_b_reg <= '0;
            aluk_reg <= 2'b00;
            dr_reg   <= 3'd0;
        end else if (accept) begin
            op_a_reg <= rf_reg[cmd_sr1];
            op_b_reg <= cmd_imm_en ? imm_sext : rf_reg[cmd_sr2];
            aluk_reg <= cmd_op;
            dr_reg   <= cmd_dr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_reg <= '0;
            rsp_cy_reg   <= 1'b0;
            nzp_reg      <= 3'b010;
        end else if (wb_en) begin
            rsp_data_reg <= alu_y;
            rsp_cy_reg   <= alu_cyo;
            nzp_reg      <= nzp_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) rf_reg[i] <= '0;
        end else if (wb_en) begin
            rf_reg[dr_reg] <= alu_y;
        end else if (rf_ld) begin
            rf_reg[ld_addr] <= ld_data;
        end
    end

    assign cmd_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign alu_op_a  = op_a_reg;
    assign alu_op_b  = op_b_reg;
    assign alu_aluk  = aluk_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_cy    = rsp_cy_reg;
    assign nzp       = nzp_reg;

endmodule
